// File: rtl/hazard_scoreboard.sv
// Register-write hazard scoreboard: per-register pending-write counters between
// decode issue and write-back retirement, generating decode's stall request.
module hazard_scoreboard #(
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        decode_valid_i,
  input  logic [4:0]  rs1_i,
  input  logic        rs1_used_i,
  input  logic [4:0]  rs2_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_write_i,
  input  logic        issue_i,
  input  logic        wb_write_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        flush_i,
  output logic        stall_request_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [31:0] stall_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // x0 is never tracked, so only entries 1..31 exist
  logic [CNT_WIDTH-1:0] cnt_q [1:31];
  logic [CNT_WIDTH-1:0] cnt_d [1:31];
  logic                 error_q, error_d;
  logic [31:0]          stall_count_q, stall_count_d;

  logic hit1, hit2, hit_full, any_busy;
  logic inc, dec;
  logic ovf, unf;
  logic stall;

  // Hazard lookup against current counter state (no retire bypass)
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit_full = 1'b0;
    any_busy = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (cnt_q[i] != '0) begin
        any_busy = 1'b1;
        if (rs1_i == 5'(i)) hit1 = 1'b1;
        if (rs2_i == 5'(i)) hit2 = 1'b1;
      end
      if (rd_i == 5'(i) && cnt_q[i] == CNT_MAX) hit_full = 1'b1;
    end
    stall = decode_valid_i & ~flush_i &
            ((rs1_used_i & hit1) | (rs2_used_i & hit2) | (rd_write_i & hit_full));
  end

  // Counter next state: flush wins; same-register inc and dec cancel
  always_comb begin
    inc = issue_i & rd_write_i & (rd_i != 5'd0);
    dec = wb_write_i & (wb_addr_i != 5'd0);
    ovf = 1'b0;
    unf = 1'b0;
    for (int unsigned i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush_i) begin
        cnt_d[i] = '0;
      end else begin
        if (inc && rd_i == 5'(i) && !(dec && wb_addr_i == 5'(i))) begin
          if (cnt_q[i] == CNT_MAX) ovf = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
        if (dec && wb_addr_i == 5'(i) && !(inc && rd_i == 5'(i))) begin
          if (cnt_q[i] == '0) unf = 1'b1;
          else                cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
    error_d       = error_q | ovf | unf | (issue_i & stall);
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 1; i < 32; i++) cnt_q[i] <= '0;
      error_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      for (int unsigned i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      error_q       <= error_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_request_o = stall;
  assign busy_o          = any_busy;
  assign error_o         = error_q;
  assign stall_count_o   = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv, rs1_used, rs2_used, rd_write, issue, wb_write, flush;
  logic [4:0]  rs1, rs2, rd, wb_addr;
  logic        stall, busy, err;
  logic [31:0] scnt;

  int tests = 0;
  int fails = 0;

  hazard_scoreboard #(.CNT_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .decode_valid_i(dv),
    .rs1_i(rs1), .rs1_used_i(rs1_used), .rs2_i(rs2), .rs2_used_i(rs2_used),
    .rd_i(rd), .rd_write_i(rd_write), .issue_i(issue),
    .wb_write_i(wb_write), .wb_addr_i(wb_addr), .flush_i(flush),
    .stall_request_o(stall), .busy_o(busy), .error_o(err), .stall_count_o(scnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dv = 0; rs1 = 0; rs1_used = 0; rs2 = 0; rs2_used = 0;
    rd = 0; rd_write = 0; issue = 0; wb_write = 0; wb_addr = 0; flush = 0;
  endtask

  // new cycle: move to negedge and clear all inputs
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;

    // reset state
    cyc(); dv = 1; rs1 = 5; rs1_used = 1; #1;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", scnt, 0);
    check("rst_err", err, 0);

    // issue rd=5, dependent read, retire
    cyc(); dv = 1; rd = 5; rd_write = 1; issue = 1; #1;
    check("iss5_stall", stall, 0);
    cyc(); dv = 1; rs2 = 5; rs2_used = 1; #1;
    check("raw5_stall", stall, 1);
    check("raw5_busy", busy, 1);
    cyc(); dv = 1; rs2 = 5; rs2_used = 1; wb_write = 1; wb_addr = 5; #1;
    check("ret5_nobypass", stall, 1);
    check("ret5_cnt1", scnt, 1);
    cyc(); dv = 1; rs2 = 5; rs2_used = 1; #1;
    check("after5_stall", stall, 0);
    check("after5_cnt", scnt, 2);
    check("after5_busy", busy, 0);

    // x0 ignored
    cyc(); dv = 1; rd = 0; rd_write = 1; issue = 1; #1;
    cyc(); dv = 1; rs1 = 0; rs1_used = 1; rs2 = 0; rs2_used = 1; #1;
    check("x0_stall", stall, 0);
    check("x0_busy", busy, 0);

    // fill x7 to max
    for (int k = 0; k < 3; k++) begin
      cyc(); dv = 1; rd = 7; rd_write = 1; issue = 1; #1;
      check("fill7_stall", stall, 0);
    end
    cyc(); dv = 1; rd = 7; rd_write = 1; #1;
    check("full7_stall", stall, 1);
    check("full7_err0", err, 0);
    cyc(); dv = 1; rd = 7; rd_write = 1; issue = 1; #1;
    check("full7_force", stall, 1);
    check("full7_cnt", scnt, 3);
    cyc(); dv = 1; rd = 7; rd_write = 1; #1;
    check("ovf_err", err, 1);
    check("ovf_hold", stall, 1);
    check("ovf_busy", busy, 1);
    check("ovf_cnt", scnt, 4);

    // async reset in the middle of a stalled cycle
    #1 rst = 1; #1;
    check("arst_stall", stall, 0);
    check("arst_err", err, 0);
    check("arst_cnt", scnt, 0);
    check("arst_busy", busy, 0);
    rst = 0;

    // same-cycle issue and retire on x9, then flush
    cyc(); dv = 1; rd = 3; rd_write = 1; issue = 1;
    cyc(); dv = 1; rd = 3; rd_write = 1; issue = 1;
    cyc(); dv = 1; rd = 9; rd_write = 1; issue = 1;
    cyc(); dv = 1; rd = 9; rd_write = 1; issue = 1; wb_write = 1; wb_addr = 9; #1;
    check("incdec9_stall", stall, 0);
    cyc(); dv = 1; rs1 = 9; rs1_used = 1; #1;
    check("incdec9_raw", stall, 1);
    check("incdec9_err", err, 0);
    cyc(); dv = 1; rs1 = 9; rs1_used = 1; rs2 = 3; rs2_used = 1;
    flush = 1; rd = 3; rd_write = 1; issue = 1; wb_write = 1; wb_addr = 9; #1;
    check("flush_mask", stall, 0);
    check("flush_cnt", scnt, 1);
    cyc(); dv = 1; rs1 = 9; rs1_used = 1; rs2 = 3; rs2_used = 1; #1;
    check("post_flush_busy", busy, 0);
    check("post_flush_stall", stall, 0);
    check("post_flush_err", err, 0);
    check("post_flush_cnt", scnt, 1);

    // issue while stalled
    cyc(); dv = 1; rd = 10; rd_write = 1; issue = 1;
    cyc(); dv = 1; rs1 = 10; rs1_used = 1; issue = 1; #1;
    check("iss_stall_req", stall, 1);
    check("iss_stall_err0", err, 0);
    cyc(); #1;
    check("iss_stall_err", err, 1);
    check("iss_stall_busy", busy, 1);

    // retire of an idle register
    rst = 1; #1; rst = 0;
    cyc(); wb_write = 1; wb_addr = 4; #1;
    check("unf_pre", err, 0);
    cyc(); #1;
    check("unf_err", err, 1);
    check("unf_busy", busy, 0);
    repeat (3) cyc();
    #1;
    check("unf_sticky", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks outstanding register writes between decode issue and write-back retirement.
- Generates the decode stage's stall request whenever the instruction held in decode reads a register that has an in-flight write pending.
- Also stalls when the instruction's destination counter would overflow.
- Sits beside decode: issue events come from decode's output handshake, retire events come from write-back.

Parameters:
CNT_WIDTH, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_WIDTH-1

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
decode_valid_i  input  1  decode holds a valid instruction this cycle
rs1_i  input  5  first source register address of the instruction in decode
rs1_used_i  input  1  instruction reads rs1
rs2_i  input  5  second source register address
rs2_used_i  input  1  instruction reads rs2
rd_i  input  5  destination register of the instruction in decode
rd_write_i  input  1  instruction writes rd
issue_i  input  1  decode output handshake fired (valid & ready) this cycle
wb_write_i  input  1  write-back commits a register write this cycle
wb_addr_i  input  5  register written by write-back
flush_i  input  1  pipeline flush; all instructions downstream of decode are killed
stall_request_o  output  1  stall request to decode (combinational)
busy_o  output  1  at least one counter non-zero (registered state, combinational OR)
error_o  output  1  sticky protocol-violation flag
stall_count_o  output  32  saturating count of stalled cycles

Behaviour:
- State: cnt[1..31], each CNT_WIDTH bits. Register x0 is never tracked; any access to address 0 is ignored.
- Reset (rst_i=1, async):
  - all cnt=0, error_o=0, stall_count_o=0.
  - Hence stall_request_o=0 and busy_o=0.
- Hazards (all combinational, from current state):
  - haz1 = rs1_used_i & rs1_i!=0 & cnt[rs1_i]!=0.
  - haz2 = same form for rs2.
  - full = rd_write_i & rd_i!=0 & cnt[rd_i]==MAX, where MAX=2^CNT_WIDTH-1.
- stall_request_o = decode_valid_i & ~flush_i & (haz1 | haz2 | full).
- No bypass: a retire in the same cycle does not clear a hazard. The register file updates at the edge, so the stall drops the following cycle.
- Counter update at each rising edge:
  - inc = issue_i & rd_write_i & rd_i!=0.
  - dec = wb_write_i & wb_addr_i!=0.
  - Different registers: each counter updated independently.
  - Same register, inc & dec: counter unchanged.
  - inc at MAX: counter holds MAX, error_o<=1.
  - dec at 0: counter holds 0, error_o<=1.
- Issue while stalled: issue_i=1 with stall_request_o=1 sets error_o<=1. The counter update still applies.
- Flush:
  - flush_i=1 clears all counters at the edge; it has priority over a same-cycle issue and retire.
  - An instruction retiring in the flush cycle is considered complete.
  - The pipeline asserts flush_i only when no killed instruction will reach write-back afterwards.
- error_o: sticky until reset.
- stall_count_o: +1 on every cycle stall_request_o=1; saturates at 32'hFFFF_FFFF; cleared only by reset.
- Latency:
  - Issue at edge N makes a dependent read stall from cycle N+1.
  - Retire at edge M releases the stall in cycle M+1, if the counter reaches 0.
- Reset mid-operation: everything clears immediately (async); stall_request_o falls in the same cycle.

Test Plan:
- Reset, then decode_valid_i=1, rs1=5 used, all counters 0 -> stall_request_o=0, busy_o=0, stall_count_o=0.
- Issue rd=5; next cycle decode reads rs2=5 -> stall_request_o=1. Retire x5 -> stall stays 1 that cycle, 0 the next; stall_count_o=2 (one stalled cycle before the retire cycle, plus the retire cycle).
- Rd=0 write issued, then read x0 -> no counter change, stall_request_o=0, busy_o=0.
- Issue rd=7 three times (CNT_WIDTH=2) -> cnt[7]=3; a fourth instruction with rd=7 in decode -> stall_request_o=1 via full. Force issue_i anyway -> error_o=1, cnt[7] stays 3.
- Same-cycle issue rd=9 and retire x9 with cnt[9]=1 -> cnt[9] remains 1, and a read of x9 still stalls. Then flush_i with cnt[3]=2 and cnt[9]=1 -> all counters 0, busy_o=0, no stall next cycle.
- Retire x4 with cnt[4]=0 -> error_o=1 and sticky. Assert rst_i asynchronously mid-stall -> stall_request_o, error_o and stall_count_o go to 0 immediately.
